dm_port_arbiter: RTL and testbench
==================================

Name: dm_port_arbiter

Overview:
- Shares the single-port data memory between two requesters: port 0 is the pipeline load/store stage, and port 1 is the debug/DMA master.
- Each access is sequenced as a three-phase transaction: capture, memory access, acknowledge.
- Arbitration is fixed priority to port 0, with an anti-starvation run limit for port 1.
- Sits between the store byte-lane formatter / load extender and the data memory. Store data and byte enables arrive already lane-formatted.

Parameters:
- AW, 32: address width.
- DW, 32: data width.
- BEW, 4: byte-enable width.
- BASE_ADDR, 32'h0000_0000: first byte address of the data memory.
- DM_WORDS, 1024: memory depth in words. Must be a power of 2.
- MAX_RUN, 4: maximum consecutive port-0 grants while port 1 is waiting. Range 1..15.

Ports:
- clk, input, 1: clock.
- rst, input, 1: asynchronous active-high reset.
- p0_req, input, 1: port 0 request. Held until p0_ack.
- p0_wr, input, 1: 1 = store, 0 = load.
- p0_addr, input, AW: byte address.
- p0_be, input, BEW: byte enables, already formatted.
- p0_wdata, input, DW: store data, already lane-replicated.
- p0_ack, output, 1: one-cycle completion pulse.
- p0_rdata, output, DW: load data. Valid while p0_ack=1.
- p0_err, output, 1: address out of range. Valid while p0_ack=1.
- p1_req, p1_wr, p1_addr, p1_be, p1_wdata, p1_ack, p1_rdata, p1_err: identical meaning for port 1.
- dm_addr, output, AW: address to the data memory.
- dm_wr, output, 1: memory write strobe.
- dm_be, output, BEW: memory byte enables.
- dm_din, output, DW: memory write data.
- dm_dout, input, DW: memory read data. Combinational from dm_addr.

Behaviour:
- Reset:
  - Interface: one clock; reset is asynchronous and active-high (ports clk, rst).
  - All registers clear: state=IDLE, cmd regs=0, run_cnt=0, rdata regs=0.
  - All outputs 0 during and after reset.
  - Reset mid-transaction aborts it. No ack is issued and no write occurs after rst rises.
- FSM: IDLE -> ACCESS -> DONE -> IDLE. Each state lasts exactly one cycle, so throughput is one transaction per 3 cycles.
- IDLE:
  - If any req, select a winner.
  - Latch the winner's id, wr, addr, be and wdata into cmd regs.
  - Compute cmd_oor = (addr < BASE_ADDR) or (addr >= BASE_ADDR + 4*DM_WORDS).
  - Go to ACCESS. With no request, stay in IDLE.
- ACCESS:
  - dm_addr/dm_be/dm_din are driven from the cmd regs.
  - dm_wr = cmd_wr & ~cmd_oor, for this cycle only.
  - Capture rdata_reg <= cmd_oor ? 0 : dm_dout. This capture happens for stores too.
- DONE:
  - Assert p<id>_ack=1 for exactly one cycle.
  - p<id>_rdata = rdata_reg and p<id>_err = cmd_oor.
  - The other port's ack, err and rdata stay 0.
- Outputs outside their state:
  - dm_wr=0 outside ACCESS.
  - dm_addr/dm_be/dm_din hold the cmd regs in every state.
- Request withdrawal:
  - The requester must drop req in the cycle after ack, or re-request.
  - A req still high in IDLE is treated as a new transaction.
  - Changing req inputs after capture has no effect on the current transaction.
- Arbitration, evaluated in IDLE only:
  - Only p0_req: grant port 0.
  - Only p1_req: grant port 1.
  - Both asserted: grant port 1 if run_cnt == MAX_RUN, otherwise grant port 0.
- run_cnt, 4 bits:
  - On a port-0 grant while p1_req=1: increment, saturating at MAX_RUN.
  - On a port-1 grant: clear to 0.
  - On a port-0 grant while p1_req=0: clear to 0.
  - Otherwise hold.
- Address arithmetic:
  - Comparison is unsigned, computed in AW+1 bits so BASE_ADDR + 4*DM_WORDS cannot wrap.
  - dm_addr is passed through unmodified. Word index extraction belongs to the memory.
- Out-of-range access:
  - No memory write.
  - rdata = 0, err = 1, ack still issued with normal 3-cycle latency.
- be = 0 store: the transaction completes normally with ack; the memory sees dm_wr=1 and modifies nothing.

Test Plan:
- Reset state: assert rst mid-ACCESS on a port-0 store to 0x10 -> no dm_wr pulse, no ack, state IDLE, all outputs 0 after release.
- Single transactions:
  - p0 store 0x11223344 to addr 0x8, be=1111, then p0 load from 0x8 -> first ack 2 cycles after capture with err=0, dm_wr high exactly one cycle.
  - Load returns p0_rdata=0x11223344 with the p0_ack pulse.
- Byte store: p1 store be=0100, wdata=0xAAAAAAAA to 0x8 over 0x11223344 -> p1 load from 0x8 returns the byte-lane-merged word matching the memory's lane mapping. p0_ack stays 0 throughout.
- Starvation limit: hold p0_req and p1_req continuously with MAX_RUN=4, each re-requesting after ack -> grant sequence 0,0,0,0,1,0,0,0,0,1. Acks spaced 3 cycles apart.
- Out of range: BASE_ADDR=0x1000, DM_WORDS=1024, p0 store to 0x2000 and p0 load from 0x0FFC -> dm_wr never asserted. Both acks carry err=1 and rdata=0. A subsequent load of 0x1FFC succeeds with err=0.
- Input instability: change p0_addr and p0_wdata during ACCESS -> the memory write uses the values captured in IDLE.

Source files
------------

// File: rtl/dm_port_arbiter.sv
// dm_port_arbiter
// Shares a single-port data memory between two requesters. Port 0 is the
// pipeline load/store stage and port 1 is the debug/DMA master. Every access
// runs as IDLE (capture) -> ACCESS (memory) -> DONE (acknowledge), one cycle
// each. Port 0 has fixed priority, but port 1 is guaranteed a grant after
// MAX_RUN consecutive port-0 grants made while it was waiting.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   pN_req/wr/addr/be/wdata       request side of port N (N = 0, 1), held until ack
//   pN_ack/rdata/err              one-cycle completion pulse with load data and
//                                 out-of-range flag (rdata/err valid with ack only)
//   dm_addr/wr/be/din             data memory command (already lane-formatted)
//   dm_dout                       data memory read data, combinational from dm_addr
module dm_port_arbiter #(
  parameter int            AW        = 32,
  parameter int            DW        = 32,
  parameter int            BEW       = 4,
  parameter logic [AW-1:0] BASE_ADDR = '0,
  parameter int            DM_WORDS  = 1024,
  parameter int            MAX_RUN   = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           p0_req,
  input  logic           p0_wr,
  input  logic [AW-1:0]  p0_addr,
  input  logic [BEW-1:0] p0_be,
  input  logic [DW-1:0]  p0_wdata,
  output logic           p0_ack,
  output logic [DW-1:0]  p0_rdata,
  output logic           p0_err,
  input  logic           p1_req,
  input  logic           p1_wr,
  input  logic [AW-1:0]  p1_addr,
  input  logic [BEW-1:0] p1_be,
  input  logic [DW-1:0]  p1_wdata,
  output logic           p1_ack,
  output logic [DW-1:0]  p1_rdata,
  output logic           p1_err,
  output logic [AW-1:0]  dm_addr,
  output logic           dm_wr,
  output logic [BEW-1:0] dm_be,
  output logic [DW-1:0]  dm_din,
  input  logic [DW-1:0]  dm_dout
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  // Range limits carry one extra bit so BASE_ADDR + 4*DM_WORDS cannot wrap.
  localparam logic [AW:0] BASE_EXT = {1'b0, BASE_ADDR};
  localparam logic [AW:0] END_EXT  = BASE_EXT + (AW+1)'(DM_WORDS * 4);
  localparam logic [3:0]  RUN_LIM  = 4'(MAX_RUN);

  state_t         state;
  logic           cmd_id;
  logic           cmd_wr;
  logic [AW-1:0]  cmd_addr;
  logic [BEW-1:0] cmd_be;
  logic [DW-1:0]  cmd_wdata;
  logic           cmd_oor;
  logic [3:0]     run_cnt;
  logic [DW-1:0]  rdata0_reg;
  logic [DW-1:0]  rdata1_reg;
  logic           ack0_reg;
  logic           ack1_reg;
  logic           wr_reg;

  logic           any_req;
  logic           sel_p1;
  logic           sel_wr;
  logic [AW-1:0]  sel_addr;
  logic [BEW-1:0] sel_be;
  logic [DW-1:0]  sel_wdata;
  logic           sel_oor;

  // Winner selection: port 1 only when alone or when port 0 has used its run.
  always_comb begin
    any_req   = p0_req | p1_req;
    sel_p1    = p1_req & (~p0_req | (run_cnt == RUN_LIM));
    sel_wr    = sel_p1 ? p1_wr    : p0_wr;
    sel_addr  = sel_p1 ? p1_addr  : p0_addr;
    sel_be    = sel_p1 ? p1_be    : p0_be;
    sel_wdata = sel_p1 ? p1_wdata : p0_wdata;
    sel_oor   = ({1'b0, sel_addr} < BASE_EXT) | ({1'b0, sel_addr} >= END_EXT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cmd_id     <= 1'b0;
      cmd_wr     <= 1'b0;
      cmd_addr   <= '0;
      cmd_be     <= '0;
      cmd_wdata  <= '0;
      cmd_oor    <= 1'b0;
      run_cnt    <= '0;
      rdata0_reg <= '0;
      rdata1_reg <= '0;
      ack0_reg   <= 1'b0;
      ack1_reg   <= 1'b0;
      wr_reg     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            cmd_id    <= sel_p1;
            cmd_wr    <= sel_wr;
            cmd_addr  <= sel_addr;
            cmd_be    <= sel_be;
            cmd_wdata <= sel_wdata;
            cmd_oor   <= sel_oor;
            // Write strobe is registered so it is high for the ACCESS cycle only.
            wr_reg    <= sel_wr & ~sel_oor;
            if (sel_p1 || !p1_req)
              run_cnt <= '0;
            else if (run_cnt != RUN_LIM)
              run_cnt <= run_cnt + 4'd1;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          wr_reg     <= 1'b0;
          // Read data is captured for stores too (pre-write memory contents).
          rdata0_reg <= (!cmd_id && !cmd_oor) ? dm_dout : '0;
          rdata1_reg <= ( cmd_id && !cmd_oor) ? dm_dout : '0;
          ack0_reg   <= ~cmd_id;
          ack1_reg   <= cmd_id;
          state      <= DONE;
        end
        DONE: begin
          rdata0_reg <= '0;
          rdata1_reg <= '0;
          ack0_reg   <= 1'b0;
          ack1_reg   <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    dm_addr  = cmd_addr;
    dm_be    = cmd_be;
    dm_din   = cmd_wdata;
    dm_wr    = wr_reg;
    p0_ack   = ack0_reg;
    p0_rdata = rdata0_reg;
    p0_err   = ack0_reg & cmd_oor;
    p1_ack   = ack1_reg;
    p1_rdata = rdata1_reg;
    p1_err   = ack1_reg & cmd_oor;
  end

endmodule

// File: tb/tb_dm_port_arbiter.sv
module tb_dm_port_arbiter;

  localparam int          DM_WORDS = 1024;
  localparam int          MAX_RUN  = 4;
  localparam logic [31:0] BASE     = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        p0_req = 0, p0_wr = 0;
  logic [31:0] p0_addr = 0, p0_wdata = 0;
  logic [3:0]  p0_be = 0;
  logic        p0_ack, p0_err;
  logic [31:0] p0_rdata;
  logic        p1_req = 0, p1_wr = 0;
  logic [31:0] p1_addr = 0, p1_wdata = 0;
  logic [3:0]  p1_be = 0;
  logic        p1_ack, p1_err;
  logic [31:0] p1_rdata;
  logic [31:0] dm_addr, dm_din, dm_dout;
  logic        dm_wr;
  logic [3:0]  dm_be;

  int n_checks = 0;
  int n_fail   = 0;
  int wr_cnt = 0, ack0_cnt = 0, ack1_cnt = 0;

  logic [31:0] mem [0:DM_WORDS-1] = '{default: 32'h0};
  logic [31:0] sh  [0:DM_WORDS-1] = '{default: 32'h0};

  dm_port_arbiter #(
    .AW(32), .DW(32), .BEW(4), .BASE_ADDR(BASE), .DM_WORDS(DM_WORDS), .MAX_RUN(MAX_RUN)
  ) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_wr(p0_wr), .p0_addr(p0_addr), .p0_be(p0_be), .p0_wdata(p0_wdata),
    .p0_ack(p0_ack), .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_req(p1_req), .p1_wr(p1_wr), .p1_addr(p1_addr), .p1_be(p1_be), .p1_wdata(p1_wdata),
    .p1_ack(p1_ack), .p1_rdata(p1_rdata), .p1_err(p1_err),
    .dm_addr(dm_addr), .dm_wr(dm_wr), .dm_be(dm_be), .dm_din(dm_din), .dm_dout(dm_dout)
  );

  always #5 clk = ~clk;

  function automatic int widx(input logic [31:0] a);
    return int'(((a - BASE) >> 2) & 32'(DM_WORDS - 1));
  endfunction

  function automatic bit out_of_range(input logic [31:0] a);
    longint ua = longint'({32'h0, a});
    return (ua < longint'(BASE)) || (ua >= longint'(BASE) + 4 * DM_WORDS);
  endfunction

  // Memory with byte lane i = bits [8i+7:8i].
  assign dm_dout = mem[widx(dm_addr)];
  always @(posedge clk)
    if (dm_wr)
      for (int b = 0; b < 4; b++)
        if (dm_be[b]) mem[widx(dm_addr)][8*b +: 8] <= dm_din[8*b +: 8];

  always @(negedge clk) begin
    if (dm_wr)  wr_cnt++;
    if (p0_ack) ack0_cnt++;
    if (p1_ack) ack1_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int p, input logic req, input logic wr, input logic [31:0] a,
                       input logic [3:0] be, input logic [31:0] wd);
    if (p == 0) begin p0_req = req; p0_wr = wr; p0_addr = a; p0_be = be; p0_wdata = wd; end
    else        begin p1_req = req; p1_wr = wr; p1_addr = a; p1_be = be; p1_wdata = wd; end
  endtask

  // Called at IDLE (#1 after a posedge); returns at IDLE.
  task automatic txn(input string tag, input int p, input logic wr, input logic [31:0] a,
                     input logic [3:0] be, input logic [31:0] wd, input bit perturb,
                     output logic [31:0] rd, output logic er);
    int lat = 0;
    bit got = 0;
    rd = '0; er = 1'b0;
    drive(p, 1'b1, wr, a, be, wd);
    while (!got && lat < 20) begin
      @(posedge clk); #1; lat++;
      if (perturb && lat == 1) begin
        p0_addr = a + 32'h4; p0_wdata = 32'hFFFF_FFFF;
        check({tag, "_dm_addr"}, dm_addr, a);
        check({tag, "_dm_din"}, dm_din, wd);
      end
      if ((p == 0 && p0_ack) || (p == 1 && p1_ack)) begin
        got = 1;
        rd  = (p == 0) ? p0_rdata : p1_rdata;
        er  = (p == 0) ? p0_err : p1_err;
        check({tag, "_other_ack"}, (p == 0) ? {31'b0, p1_ack} : {31'b0, p0_ack}, 32'd0);
      end
    end
    check({tag, "_ack_seen"}, {31'b0, got}, 32'd1);
    check({tag, "_latency"}, lat, 32'd2);
    if (p == 0) p0_req = 1'b0; else p1_req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_dm_addr"}, dm_addr, 32'd0);
    check({tag, "_dm_wr"}, {31'b0, dm_wr}, 32'd0);
    check({tag, "_dm_be_din"}, {28'b0, dm_be} | dm_din, 32'd0);
    check({tag, "_acks"}, {30'b0, p0_ack, p1_ack}, 32'd0);
    check({tag, "_errs"}, {30'b0, p0_err, p1_err}, 32'd0);
    check({tag, "_rdata"}, p0_rdata | p1_rdata, 32'd0);
  endtask

  function automatic logic [31:0] rand_addr();
    int r = $urandom_range(0, 9);
    if (r == 0) return BASE - 32'd4;
    if (r == 1) return BASE + 32'd4096;
    if (r == 2) return 32'hFFFF_FFFC;
    return BASE + 32'(4 * $urandom_range(0, 15));
  endfunction

  initial begin
    logic [31:0] rd;
    logic er;
    int w0, a0, a1, consec, win, lat;
    bit got;
    bit pend [2];
    logic pw [2];
    logic [31:0] pa [2], pd [2];
    logic [3:0] pb [2];
    int exp_seq [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    logic [31:0] exp_rd;
    logic exp_er;

    // Reset state
    #1;
    check_outputs_zero("in_reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check_outputs_zero("after_reset");

    // Reset mid-ACCESS aborts a store
    drive(0, 1'b1, 1'b1, BASE + 32'h10, 4'hF, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    check("abort_in_access_dm_wr", {31'b0, dm_wr}, 32'd1);
    w0 = wr_cnt; a0 = ack0_cnt;
    #1 rst = 1'b1;
    #1 check("abort_dm_wr_drop", {31'b0, dm_wr}, 32'd0);
    p0_req = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("abort_no_write", wr_cnt, w0);
    check("abort_no_ack", ack0_cnt, a0);
    check("abort_mem_untouched", mem[widx(BASE + 32'h10)], 32'd0);
    check_outputs_zero("abort_after");

    // Full-word store then load on port 0
    w0 = wr_cnt;
    txn("p0_store", 0, 1'b1, BASE + 32'h8, 4'hF, 32'h1122_3344, 0, rd, er);
    check("p0_store_err", {31'b0, er}, 32'd0);
    check("p0_store_one_wr", wr_cnt - w0, 32'd1);
    txn("p0_load", 0, 1'b0, BASE + 32'h8, 4'hF, 32'h0, 0, rd, er);
    check("p0_load_rdata", rd, 32'h1122_3344);
    check("p0_load_err", {31'b0, er}, 32'd0);

    // Byte-lane store on port 1
    a0 = ack0_cnt;
    txn("p1_bstore", 1, 1'b1, BASE + 32'h8, 4'b0100, 32'hAAAA_AAAA, 0, rd, er);
    check("p1_bstore_old", rd, 32'h1122_3344);
    txn("p1_load", 1, 1'b0, BASE + 32'h8, 4'hF, 32'h0, 0, rd, er);
    check("p1_load_merged", rd, 32'h11AA_3344);
    check("p1_no_p0_ack", ack0_cnt, a0);

    // Out of range
    w0 = wr_cnt;
    txn("oor_store", 0, 1'b1, 32'h0000_2000, 4'hF, 32'h5555_5555, 0, rd, er);
    check("oor_store_err", {31'b0, er}, 32'd1);
    check("oor_store_rdata", rd, 32'd0);
    txn("oor_load", 0, 1'b0, 32'h0000_0FFC, 4'hF, 32'h0, 0, rd, er);
    check("oor_load_err", {31'b0, er}, 32'd1);
    check("oor_load_rdata", rd, 32'd0);
    check("oor_no_write", wr_cnt, w0);
    check("oor_mem0_intact", mem[0], 32'd0);
    txn("top_store", 0, 1'b1, 32'h0000_1FFC, 4'hF, 32'hCAFE_F00D, 0, rd, er);
    txn("top_load", 0, 1'b0, 32'h0000_1FFC, 4'hF, 32'h0, 0, rd, er);
    check("top_load_err", {31'b0, er}, 32'd0);
    check("top_load_rdata", rd, 32'hCAFE_F00D);

    // Inputs changed during ACCESS do not affect the write
    txn("unstable", 0, 1'b1, BASE + 32'h20, 4'hF, 32'h5A5A_5A5A, 1, rd, er);
    txn("unstable_ld0", 0, 1'b0, BASE + 32'h20, 4'hF, 32'h0, 0, rd, er);
    check("unstable_captured", rd, 32'h5A5A_5A5A);
    txn("unstable_ld1", 0, 1'b0, BASE + 32'h24, 4'hF, 32'h0, 0, rd, er);
    check("unstable_neighbour", rd, 32'd0);

    // Starvation limit: both ports request continuously
    sh[widx(BASE + 32'h8)]    = 32'h11AA_3344;
    sh[widx(BASE + 32'h20)]   = 32'h5A5A_5A5A;
    sh[widx(32'h0000_1FFC)]   = 32'hCAFE_F00D;
    drive(0, 1'b1, 1'b0, BASE + 32'h8, 4'hF, 32'h0);
    drive(1, 1'b1, 1'b0, BASE + 32'h20, 4'hF, 32'h0);
    for (int k = 0; k < 10; k++) begin
      lat = 0; got = 0;
      while (!got && lat < 20) begin
        @(posedge clk); #1; lat++;
        got = p0_ack | p1_ack;
      end
      check($sformatf("starve_ack%0d_seen", k), {31'b0, got}, 32'd1);
      check($sformatf("starve_ack%0d_port", k), {30'b0, p1_ack, p0_ack},
            (exp_seq[k] == 1) ? 32'd2 : 32'd1);
      check($sformatf("starve_ack%0d_spacing", k), lat, (k == 0) ? 32'd2 : 32'd3);
    end
    p0_req = 1'b0; p1_req = 1'b0;
    @(posedge clk); #1;

    // Randomized traffic against the reference model
    consec = 0;
    pend[0] = 0; pend[1] = 0;
    for (int it = 0; it < 60; it++) begin
      for (int p = 0; p < 2; p++)
        if (!pend[p] && $urandom_range(0, 2) != 0) begin
          pend[p] = 1; pw[p] = 1'($urandom_range(0, 1)); pa[p] = rand_addr();
          pb[p] = 4'($urandom_range(0, 15)); pd[p] = $urandom;
        end
      if (!pend[0] && !pend[1]) begin
        pend[0] = 1; pw[0] = 1'b0; pa[0] = rand_addr(); pb[0] = 4'hF; pd[0] = 32'h0;
      end
      for (int p = 0; p < 2; p++) drive(p, pend[p], pw[p], pa[p], pb[p], pd[p]);
      // Who should win: port 0 unless it has already had MAX_RUN grants in a row
      // while port 1 was waiting.
      if (pend[0] && pend[1]) win = (consec >= MAX_RUN) ? 1 : 0;
      else win = pend[1] ? 1 : 0;
      if (win == 0 && pend[1]) consec = consec + 1;
      else consec = 0;
      exp_er = out_of_range(pa[win]);
      exp_rd = exp_er ? 32'd0 : sh[widx(pa[win])];
      lat = 0; got = 0;
      while (!got && lat < 20) begin
        @(posedge clk); #1; lat++;
        got = p0_ack | p1_ack;
      end
      check("rnd_ack_seen", {31'b0, got}, 32'd1);
      check("rnd_latency", lat, 32'd2);
      check("rnd_port", {30'b0, p1_ack, p0_ack}, (win == 1) ? 32'd2 : 32'd1);
      check("rnd_rdata", (win == 1) ? p1_rdata : p0_rdata, exp_rd);
      check("rnd_err", {31'b0, (win == 1) ? p1_err : p0_err}, {31'b0, exp_er});
      check("rnd_loser_quiet", (win == 1) ? (p0_rdata | {31'b0, p0_err}) : (p1_rdata | {31'b0, p1_err}), 32'd0);
      if (pw[win] && !exp_er)
        for (int b = 0; b < 4; b++)
          if (pb[win][b]) sh[widx(pa[win])][8*b +: 8] = pd[win][8*b +: 8];
      pend[win] = 0;
      if (win == 0) p0_req = 1'b0; else p1_req = 1'b0;
      @(posedge clk); #1;
    end
    p0_req = 1'b0; p1_req = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++)
      check($sformatf("final_mem%0d", i), mem[widx(BASE + 32'(4 * i))], sh[widx(BASE + 32'(4 * i))]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
